// File: rtl/ext_addr_pipe.sv
// LC-3 immediate extract/extend with optional base add, behind a 2-entry skid buffer.
// Latency 1 cycle; in_ready is state-derived and never combinationally depends on out_ready.
module ext_addr_pipe #(
   parameter int DATA_WIDTH = 16,
   parameter int TRAP_SHIFT = 0
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [15:0]           ir,
   input  logic [2:0]            mode,
   input  logic                  add_en,
   input  logic [DATA_WIDTH-1:0] base,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  err
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] ext_d, sum_d, trap_zx;
   logic                  err_d;
   logic [DATA_WIDTH-1:0] or_dat, sr_dat;
   logic                  or_err, sr_err;
   logic                  or_vld, sr_vld;
   logic                  in_xfer, out_xfer;
   logic                  ld_or_new, ld_or_sr, ld_sr;
   logic                  unused_ir;

   assign unused_ir = ^ir[15:11];
   assign trap_zx   = {{(DATA_WIDTH-8){1'b0}}, ir[7:0]};

   always_comb begin
      ext_d = '0;
      err_d = 1'b0;
      unique case (mode)
         3'd0:    ext_d = {{(DATA_WIDTH-5){ir[4]}},  ir[4:0]};
         3'd1:    ext_d = {{(DATA_WIDTH-6){ir[5]}},  ir[5:0]};
         3'd2:    ext_d = {{(DATA_WIDTH-9){ir[8]}},  ir[8:0]};
         3'd3:    ext_d = {{(DATA_WIDTH-11){ir[10]}}, ir[10:0]};
         3'd4:    ext_d = trap_zx;
         3'd5:    ext_d = trap_zx << TRAP_SHIFT;
         default: err_d = 1'b1;
      endcase
   end

   // Base is added even for illegal modes; carry-out falls off the top.
   assign sum_d = add_en ? (base + ext_d) : ext_d;

   assign or_vld    = (state_q == ONE) || (state_q == TWO);
   assign sr_vld    = (state_q == TWO);
   assign in_ready  = !sr_vld && !Reset;
   assign out_valid = or_vld;
   assign result    = or_dat;
   assign err       = or_err;

   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = or_vld && out_ready;

   always_comb begin
      state_d   = state_q;
      ld_or_new = 1'b0;
      ld_or_sr  = 1'b0;
      ld_sr     = 1'b0;
      case (state_q)
         EMPTY: begin
            if (in_xfer) begin
               state_d   = ONE;
               ld_or_new = 1'b1;
            end
         end
         ONE: begin
            if (in_xfer && !out_xfer) begin
               state_d = TWO;
               ld_sr   = 1'b1;
            end else if (!in_xfer && out_xfer) begin
               state_d = EMPTY;
            end else if (in_xfer && out_xfer) begin
               ld_or_new = 1'b1;
            end
         end
         TWO: begin
            if (out_xfer) begin
               state_d  = ONE;
               ld_or_sr = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         or_dat <= '0;
         or_err <= 1'b0;
         sr_dat <= '0;
         sr_err <= 1'b0;
      end else begin
         if (ld_or_new) begin
            or_dat <= sum_d;
            or_err <= err_d;
         end else if (ld_or_sr) begin
            or_dat <= sr_dat;
            or_err <= sr_err;
         end
         if (ld_sr) begin
            sr_dat <= sum_d;
            sr_err <= err_d;
         end
      end
   end

endmodule

// File: tb/tb_ext_addr_pipe.sv
// Bench for ext_addr_pipe: vector tables, corner sequences and a randomized scoreboard run.
module tb_ext_addr_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, add_en, out_valid, out_ready, err;
   logic [15:0] ir, base, result;
   logic [2:0]  mode;

   logic        in_valid32, in_ready32, add_en32, out_valid32, err32;
   logic [15:0] ir32;
   logic [2:0]  mode32;
   logic [31:0] base32, result32;
   logic        out_ready32 = 1'b1;

   int checks = 0;
   int errors = 0;

   logic [32:0] q[$];

   typedef struct {
      logic [15:0] ir;
      logic [2:0]  mode;
      logic        add_en;
      logic [31:0] base;
      logic [31:0] exp;
      logic        exp_err;
   } vec_t;

   vec_t t16[10];
   vec_t t32[4];

   always #5 clk = ~clk;

   ext_addr_pipe #(.DATA_WIDTH(16), .TRAP_SHIFT(1)) dut (
      .Clk(clk), .Reset(rst), .in_valid(in_valid), .in_ready(in_ready),
      .ir(ir), .mode(mode), .add_en(add_en), .base(base),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .err(err)
   );

   ext_addr_pipe #(.DATA_WIDTH(32), .TRAP_SHIFT(3)) dut32 (
      .Clk(clk), .Reset(rst), .in_valid(in_valid32), .in_ready(in_ready32),
      .ir(ir32), .mode(mode32), .add_en(add_en32), .base(base32),
      .out_valid(out_valid32), .out_ready(out_ready32), .result(result32), .err(err32)
   );

   task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Field value as a signed integer from the mode rules, then plain modular arithmetic.
   function automatic logic [32:0] model(input logic [15:0] i, input logic [2:0] m,
                                         input logic a, input logic [31:0] b,
                                         input int dw, input int sh);
      longint v, md;
      int     w;
      bit     s;
      md = longint'(1) << dw;
      w  = 0;
      s  = 1'b0;
      case (m)
         3'd0: begin w = 5;  s = 1'b1; end
         3'd1: begin w = 6;  s = 1'b1; end
         3'd2: begin w = 9;  s = 1'b1; end
         3'd3: begin w = 11; s = 1'b1; end
         3'd4, 3'd5: w = 8;
         default: w = 0;
      endcase
      v = 0;
      if (w != 0) begin
         v = longint'(i) % (longint'(1) << w);
         if (s && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
         if (m == 3'd5) v = v * (longint'(1) << sh);
      end
      if (a) v = v + longint'(b);
      v = ((v % md) + md) % md;
      return {(w == 0), v[31:0]};
   endfunction

   // Scoreboard on the 16-bit unit: occupancy, ordering and values.
   always @(negedge clk) begin
      logic [32:0] e;
      if (rst) begin
         chk("in_ready_during_reset", {32'd0, in_ready}, 33'd0);
         q.delete();
      end else begin
         chk("in_ready_vs_occupancy", {32'd0, in_ready}, {32'd0, q.size() < 2});
         chk("out_valid_vs_occupancy", {32'd0, out_valid}, {32'd0, q.size() != 0});
         if (out_valid && out_ready && q.size() != 0) begin
            e = q.pop_front();
            chk("sb_result", {17'd0, result}, {17'd0, e[15:0]});
            chk("sb_err", {32'd0, err}, {32'd0, e[32]});
         end
         if (in_valid && in_ready)
            q.push_back(model(ir, mode, add_en, {16'd0, base}, 16, 1));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [15:0] i, input logic [2:0] m, input logic a,
                        input logic [15:0] b);
      ir = i; mode = m; add_en = a; base = b; in_valid = 1'b1;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [32:0] m;
      t16[0] = '{16'h0010, 3'd0, 1'b0, 32'hABCD, 32'hFFF0, 1'b0};
      t16[1] = '{16'h001F, 3'd1, 1'b0, 32'hABCD, 32'h001F, 1'b0};
      t16[2] = '{16'h0100, 3'd2, 1'b0, 32'h0000, 32'hFF00, 1'b0};
      t16[3] = '{16'h0400, 3'd3, 1'b0, 32'h0000, 32'hFC00, 1'b0};
      t16[4] = '{16'h00FF, 3'd4, 1'b0, 32'h0000, 32'h00FF, 1'b0};
      t16[5] = '{16'h0025, 3'd5, 1'b0, 32'h0000, 32'h004A, 1'b0};
      t16[6] = '{16'h01FF, 3'd2, 1'b1, 32'h3000, 32'h2FFF, 1'b0};
      t16[7] = '{16'h0001, 3'd0, 1'b1, 32'hFFFF, 32'h0000, 1'b0};
      t16[8] = '{16'hFFFF, 3'd6, 1'b0, 32'h5555, 32'h0000, 1'b1};
      t16[9] = '{16'h0ABC, 3'd7, 1'b1, 32'h1234, 32'h1234, 1'b1};
      t32[0] = '{16'h0400, 3'd3, 1'b0, 32'h0,         32'hFFFFFC00, 1'b0};
      t32[1] = '{16'h00FF, 3'd5, 1'b0, 32'h0,         32'h000007F8, 1'b0};
      t32[2] = '{16'h0001, 3'd0, 1'b1, 32'hFFFFFFFF,  32'h00000000, 1'b0};
      t32[3] = '{16'h0010, 3'd0, 1'b1, 32'h00010000,  32'h0000FFF0, 1'b0};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      ir = '0; mode = '0; add_en = 1'b0; base = '0;
      in_valid32 = 1'b0; ir32 = '0; mode32 = '0; add_en32 = 1'b0; base32 = '0;
      tick(); tick();
      chk("reset_in_ready", {32'd0, in_ready}, 33'd0);
      chk("reset_out_valid", {32'd0, out_valid}, 33'd0);
      chk("reset_result", {17'd0, result}, 33'd0);
      chk("reset_err", {32'd0, err}, 33'd0);
      rst = 1'b0;
      #1;
      chk("in_ready_after_reset", {32'd0, in_ready}, 33'd1);

      // Mode sweep, PC add/wrap and illegal modes; each result one cycle after its transfer.
      for (int i = 0; i < 10; i++) begin
         drive(t16[i].ir, t16[i].mode, t16[i].add_en, t16[i].base[15:0]);
         tick();
         in_valid = 1'b0;
         chk($sformatf("vec%0d_valid", i), {32'd0, out_valid}, 33'd1);
         chk($sformatf("vec%0d_result", i), {17'd0, result}, {1'b0, t16[i].exp});
         chk($sformatf("vec%0d_err", i), {32'd0, err}, {32'd0, t16[i].exp_err});
      end
      tick();

      // Backpressure: A, B fill both entries, C must wait, order preserved.
      out_ready = 1'b0;
      drive(16'h0005, 3'd0, 1'b0, 16'h0);
      tick();
      drive(16'h003F, 3'd1, 1'b0, 16'h0);
      tick();
      chk("bp_in_ready_two", {32'd0, in_ready}, 33'd0);
      chk("bp_result_a", {17'd0, result}, 33'h0005);
      drive(16'h00AA, 3'd4, 1'b0, 16'h0);
      tick();
      chk("bp_c_refused", {32'd0, in_ready}, 33'd0);
      chk("bp_hold_a", {17'd0, result}, 33'h0005);
      out_ready = 1'b1;
      tick();
      chk("bp_result_b", {17'd0, result}, 33'hFFFF);
      tick();
      in_valid = 1'b0;
      chk("bp_result_c", {17'd0, result}, 33'h00AA);
      tick();
      chk("bp_drained", {32'd0, out_valid}, 33'd0);

      // Streaming: 20 back-to-back transfers, no bubbles.
      for (int i = 0; i < 20; i++) begin
         drive(16'($urandom), 3'(i % 6), 1'($urandom), 16'($urandom));
         tick();
         chk("stream_in_ready", {32'd0, in_ready}, 33'd1);
         chk("stream_out_valid", {32'd0, out_valid}, 33'd1);
      end
      in_valid = 1'b0;
      tick();
      chk("stream_done", {32'd0, out_valid}, 33'd0);

      // Reset while both entries are full.
      out_ready = 1'b0;
      drive(16'h0011, 3'd0, 1'b0, 16'h0);
      tick();
      drive(16'h0022, 3'd1, 1'b0, 16'h0);
      tick();
      in_valid = 1'b0;
      chk("rst_two_full", {32'd0, in_ready}, 33'd0);
      rst = 1'b1;
      in_valid = 1'b1;
      #1;
      chk("rst_in_ready_low", {32'd0, in_ready}, 33'd0);
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("rst_out_valid", {32'd0, out_valid}, 33'd0);
      chk("rst_result", {17'd0, result}, 33'd0);
      chk("rst_err", {32'd0, err}, 33'd0);
      chk("rst_in_ready_back", {32'd0, in_ready}, 33'd1);
      out_ready = 1'b1;
      drive(16'h0400, 3'd3, 1'b0, 16'h0);
      tick();
      in_valid = 1'b0;
      chk("post_rst_valid", {32'd0, out_valid}, 33'd1);
      chk("post_rst_result", {17'd0, result}, 33'hFC00);
      tick();

      // Randomized traffic with occasional resets against the scoreboard.
      for (int c = 0; c < 3000; c++) begin
         rst       = ($urandom_range(0, 299) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         drive(16'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), 16'($urandom));
         in_valid  = 1'($urandom);
         tick();
      end
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) tick();
      chk("random_drain", 33'(q.size()), 33'd0);

      // 32-bit instance: fixed vectors, then random single shots against the model.
      for (int i = 0; i < 4; i++) begin
         ir32 = t32[i].ir; mode32 = t32[i].mode; add_en32 = t32[i].add_en;
         base32 = t32[i].base; in_valid32 = 1'b1;
         tick();
         in_valid32 = 1'b0;
         chk($sformatf("w32_vec%0d_valid", i), {32'd0, out_valid32}, 33'd1);
         chk($sformatf("w32_vec%0d_result", i), {1'b0, result32}, {1'b0, t32[i].exp});
         chk($sformatf("w32_vec%0d_err", i), {32'd0, err32}, {32'd0, t32[i].exp_err});
      end
      for (int i = 0; i < 200; i++) begin
         ir32 = 16'($urandom); mode32 = 3'($urandom_range(0, 7));
         add_en32 = 1'($urandom); base32 = $urandom; in_valid32 = 1'b1;
         m = model(ir32, mode32, add_en32, base32, 32, 3);
         tick();
         in_valid32 = 1'b0;
         chk("w32_rand_result", {1'b0, result32}, {1'b0, m[31:0]});
         chk("w32_rand_err", {32'd0, err32}, {32'd0, m[32]});
      end
      tick();
      chk("w32_in_ready", {32'd0, in_ready32}, 33'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
